// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller: one shared datapath, one bit per cycle,
// owning the architectural HI/LO registers.
module mdu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, nxt;
   logic [1:0]         op_r;
   logic               sa, sb;
   logic [WIDTH-1:0]   mb;
   logic [5:0]         cnt;
   // multiply: {partial product, remaining multiplier bits}
   // divide:   low half shifts dividend out and quotient in
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic               accept;
   logic               sgn_in, sa_in, sb_in;
   logic [WIDTH-1:0]   ma_in, mb_in;
   logic [WIDTH:0]     msum, shf, dif;
   logic               take;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rmd;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = RUN;
         RUN:     if (cnt == 6'd31) nxt = FIX;
         FIX:     nxt = start ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   // FIX retires the old op and may launch the next one in the same edge
   assign accept = start && (state == IDLE || state == FIX);
   assign busy   = (state != IDLE);

   assign sgn_in = ~op[0];
   assign sa_in  = sgn_in & a[WIDTH-1];
   assign sb_in  = sgn_in & b[WIDTH-1];
   assign ma_in  = sa_in ? -a : a;
   assign mb_in  = sb_in ? -b : b;

   assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
   assign shf  = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign dif  = shf - {1'b0, mb};
   assign take = (shf >= {1'b0, mb});

   assign prod = (sa ^ sb) ? -acc : acc;
   assign quo  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rmd  = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
         op_r <= '0;
         sa   <= 1'b0;
         sb   <= 1'b0;
         mb   <= '0;
         cnt  <= '0;
         acc  <= '0;
         rem  <= '0;
      end else begin
         done <= 1'b0;
         if (state == FIX) begin
            done <= 1'b1;
            if (op_r[1]) begin
               hi <= rmd;
               lo <= quo;
            end else begin
               {hi, lo} <= prod;
            end
         end
         if (state == IDLE && !start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
         if (accept) begin
            op_r <= op;
            sa   <= sa_in;
            sb   <= sb_in;
            mb   <= mb_in;
            cnt  <= '0;
            acc  <= {{WIDTH{1'b0}}, ma_in};
            rem  <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            if (op_r[1]) begin
               rem             <= take ? dif : shf;
               acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], take};
            end else begin
               acc <= {msum, acc[WIDTH-1:1]};
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed MULT/DIV results, timing,
// ignored requests, back-to-back launch and reset abort.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, wdata = '0;
   logic        mthi = 1'b0, mtlo = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad = 0;
   int n, nb, dcnt;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   // called right after the accepting edge; counts edges until done shows up
   task automatic wait_done(output int cyc, output int nbusy);
      nbusy = busy ? 1 : 0;
      cyc = 0;
      while (cyc < 100) begin
         tick();
         cyc++;
         if (done) break;
         if (busy) nbusy++;
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      reset = 1'b1;
      tick();

      // MULTU max x max, with latency and busy length
      launch(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(n, nb);
      chk("multu_lat", n, 32'd33);
      chk("multu_busy", nb, 32'd33);
      chk("multu_busy_end", {31'b0, busy}, 32'd0);
      chk("multu_hi", hi, 32'hFFFFFFFE);
      chk("multu_lo", lo, 32'h00000001);
      tick();
      chk("done_pulse", {31'b0, done}, 32'd0);

      // MULT -3 x 7, HI held during RUN
      launch(MULT, 32'hFFFFFFFD, 32'd7);
      chk("run_hold_hi", hi, 32'hFFFFFFFE);
      wait_done(n, nb);
      chk("mult_lat", n, 32'd33);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFEB);
      tick();

      // DIV -7/2, then back-to-back DIV overflow launched at the FIX edge
      launch(DIV, 32'hFFFFFFF9, 32'd2);
      repeat (32) tick();
      chk("b2b_pre_done", {31'b0, done}, 32'd0);
      start = 1'b1; op = DIV; a = 32'h80000000; b = 32'hFFFFFFFF;
      tick();
      start = 1'b0;
      chk("div_done", {31'b0, done}, 32'd1);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      wait_done(n, nb);
      chk("b2b_lat", n, 32'd33);
      chk("ovf_lo", lo, 32'h80000000);
      chk("ovf_hi", hi, 32'h0);
      tick();

      // divide by zero and ordinary DIVU
      launch(DIVU, 32'd100, 32'd0);
      wait_done(n, nb);
      chk("divu0_lo", lo, 32'hFFFFFFFF);
      chk("divu0_hi", hi, 32'd100);
      tick();
      launch(DIV, 32'hFFFFFF9C, 32'd0);
      wait_done(n, nb);
      chk("div0neg_lo", lo, 32'h00000001);
      chk("div0neg_hi", hi, 32'hFFFFFF9C);
      tick();
      launch(DIVU, 32'd100, 32'd7);
      wait_done(n, nb);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      tick();

      // start and mthi during RUN are ignored
      launch(MULTU, 32'd5, 32'd5);
      repeat (9) tick();
      start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9; mthi = 1'b1; wdata = 32'hDEADBEEF;
      tick();
      start = 1'b0; mthi = 1'b0;
      chk("ign_mthi_hi", hi, 32'd2);
      dcnt = 0;
      while (!done && dcnt < 60) begin tick(); dcnt++; end
      chk("ign_lat", dcnt, 32'd23);
      chk("ign_lo", lo, 32'd25);
      chk("ign_hi", hi, 32'd0);
      tick();
      chk("ign_no_relaunch", {31'b0, busy}, 32'd0);

      // MTLO, then MTHI+MTLO together in IDLE
      mtlo = 1'b1; wdata = 32'h1234;
      tick();
      mtlo = 1'b0;
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_hi", hi, 32'd0);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      chk("mtboth_hi", hi, 32'hA5A5A5A5);
      chk("mtboth_lo", lo, 32'hA5A5A5A5);

      // start beats mthi in IDLE: the write is dropped
      mthi = 1'b1; wdata = 32'h0BADF00D;
      launch(MULTU, 32'd3, 32'd4);
      mthi = 1'b0;
      chk("start_beats_mthi", hi, 32'hA5A5A5A5);
      wait_done(n, nb);
      chk("sm_lo", lo, 32'd12);
      chk("sm_hi", hi, 32'd0);
      mtlo = 1'b1; wdata = 32'h77;
      tick();
      mtlo = 1'b0;

      // reset aborts an op in flight
      launch(DIVU, 32'd100, 32'd7);
      repeat (11) tick();
      reset = 1'b0;
      tick();
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      reset = 1'b1;
      dcnt = 0;
      repeat (40) begin tick(); if (done || busy) dcnt++; end
      chk("abort_quiet", dcnt, 32'd0);
      launch(MULTU, 32'd2, 32'd3);
      wait_done(n, nb);
      chk("post_rst_lat", n, 32'd33);
      chk("post_rst_lo", lo, 32'd6);
      chk("post_rst_hi", hi, 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
